// File: rtl/svi_chan_src_pipe.sv
// Per-channel source select (const / all-ones / input / hold) feeding a DEPTH-stage
// valid-qualified delay line under one global stall, with a saturating accept counter.
module svi_chan_src_pipe #(
   parameter int unsigned          N_CH      = 4,
   parameter int unsigned          W         = 8,
   parameter int unsigned          DEPTH     = 2,
   parameter logic [W-1:0]         CONST_VAL = '0,
   parameter int unsigned          CNT_W     = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [N_CH-1:0]                 i_valid,
   input  logic [N_CH-1:0][W-1:0]          i_data,
   input  logic [N_CH-1:0][1:0]            i_mode,
   input  logic                            i_stall,
   output logic [N_CH-1:0]                 o_valid,
   output logic [N_CH-1:0][W-1:0]          o_data,
   output logic [N_CH-1:0][CNT_W-1:0]      o_cnt
);

   localparam logic [1:0] MODE_CONST   = 2'd0;
   localparam logic [1:0] MODE_LITERAL = 2'd1;
   localparam logic [1:0] MODE_SIGNAL  = 2'd2;
   localparam logic [1:0] MODE_HOLD    = 2'd3;

   logic [N_CH-1:0][DEPTH-1:0][W-1:0] data_q, data_d;
   logic [N_CH-1:0][DEPTH-1:0]        vld_q,  vld_d;
   logic [N_CH-1:0][CNT_W-1:0]        cnt_q,  cnt_d;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      cnt_d  = cnt_q;
      if (!i_stall) begin
         for (int c = 0; c < int'(N_CH); c++) begin
            vld_d[c][0] = i_valid[c];
            if (i_valid[c]) begin
               case (i_mode[c])
                  MODE_CONST:   data_d[c][0] = CONST_VAL;
                  MODE_LITERAL: data_d[c][0] = {W{1'b1}};
                  MODE_SIGNAL:  data_d[c][0] = i_data[c];
                  MODE_HOLD:    data_d[c][0] = data_q[c][0];
                  default:      data_d[c][0] = data_q[c][0];
               endcase
               if (cnt_q[c] != {CNT_W{1'b1}})
                  cnt_d[c] = cnt_q[c] + 1'b1;
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
               data_d[c][k] = data_q[c][k-1];
               vld_d[c][k]  = vld_q[c][k-1];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q <= {(N_CH*DEPTH){CONST_VAL}};
         vld_q  <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         cnt_q  <= cnt_d;
      end
   end

   // Outputs come straight from the last stage registers: no input-to-output path.
   always_comb begin
      o_valid = '0;
      o_data  = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
         o_valid[c] = vld_q[c][DEPTH-1];
         o_data[c]  = data_q[c][DEPTH-1];
      end
      o_cnt = cnt_q;
   end

endmodule
